commit_controller: RTL and testbench
====================================

# commit_controller

In-order retirement sequencer that sits between the reorder buffer head and the back-end state holders: free list, architectural RAT, store buffer and branch predictor. Each cycle it inspects the two oldest ROB entries and retires up to two finished instructions in program order. It returns old physical registers, commits stores and trains the predictor. On a mispredicted branch at the head, it runs a flush/redirect/recovery sequence.

## Interface
Parameters:
- NUM_ROB_ENTRY, 16: ROB depth.
- ROB_WIDTH, 4: log2(NUM_ROB_ENTRY).
- PHY_WIDTH, 6: physical register index width.
- ARCH_WIDTH, 5: architectural register index width.
- XLEN, 32: address width.
- RECOVER_CYCLES, 2: commit-blocked cycles after flush, ≥1.

Ports:
- clk, in, 1: clock; all state on rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- rob_count, in, ROB_WIDTH+1: valid ROB entries.
- head_finish, in, 2: bit0 = FINISH[head], bit1 = FINISH[head+1].
- head_entry_0, in, ROB_ENTRY_t: entry at head.
- head_entry_1, in, ROB_ENTRY_t: entry at head+1 (mod NUM_ROB_ENTRY).
- commit_cnt, out, 2: head advance this cycle (0..2).
- retire_valid, out, 2: per-slot retire strobe.
- free_valid, out, 2: per-slot free-list return.
- free_phy_0 and free_phy_1, out, PHY_WIDTH each: rd_phy_old per slot.
- arat_we, out, 2: architectural RAT write enables.
- arat_arch_0 and arat_arch_1, out, ARCH_WIDTH each: rd_arch per slot.
- arat_phy_0 and arat_phy_1, out, PHY_WIDTH each: rd_phy_new per slot.
- store_commit_valid, out, 1: store at retirement.
- store_commit_id, out, store_id width: store_id of that store.
- bp_update_valid, out, 1: predictor training strobe.
- bp_update_pc, out, XLEN: update_pc of the branch.
- bp_update_target, out, XLEN: actual_target of the branch.
- bp_update_taken, out, 1: actual_taken of the branch.
- flush, out, 1: pipeline-wide flush, registered.
- redirect_valid, out, 1: fetch redirect, registered.
- redirect_pc, out, XLEN: corrected fetch PC, registered.
- recovering, out, 1: high in FLUSH and RECOVER states.
- instret, out, 64: retired-instruction counter.

## Operation
- FSM states: RUN, FLUSH, RECOVER. Reset state is RUN.
- Slot 0 commits when all hold:
  - state == RUN
  - rob_count ≥ 1
  - head_finish[0]
- Slot 1 commits when all hold:
  - slot 0 commits
  - rob_count ≥ 2
  - head_finish[1]
  - head_entry_0.mispredict == 0
  - not both slots are stores, since there is one store port
  - not both slots are branch/jump, since there is one predictor port
- commit_cnt = number of committing slots. retire_valid mirrors the committing slots.
- Per committing slot with rd_arch != 0:
  - free_valid = 1, free_phy = rd_phy_old.
  - arat_we = 1, arat_arch = rd_arch, arat_phy = rd_phy_new.
- Per committing slot with rd_arch == 0: no free and no ARAT write.
- Both slots write the same rd_arch: both arat_we assert and the RAT applies slot 1 last; both old registers are freed.
- Store/branch/jump classification comes from opcode using instruction_pkg constants.
- Committing store: store_commit_valid = 1, store_commit_id = store_id.
- Committing branch or jump: bp_update_* are driven from that entry's fields.
- Slot 0 commits with mispredict = 1:
  - It retires normally in that cycle, including ARAT write and predictor update.
  - redirect_pc is latched from actual_target.
  - FSM moves RUN to FLUSH.
- FLUSH state lasts 1 cycle:
  - flush = 1, redirect_valid = 1, commit_cnt = 0.
  - Next state is RECOVER; the counter loads RECOVER_CYCLES-1.
- RECOVER state: commit_cnt = 0; the counter decrements each cycle. When it reaches 0, the next state is RUN.
- instret increments by commit_cnt every cycle and wraps at 2^64.
- All retire, free, arat, store and bp outputs are 0 whenever commit_cnt would be 0.

## Timing
- Retire, free, arat, store and bp outputs are combinational from the head inputs and the current state. The ROB consumes commit_cnt at the same rising edge.
- flush, redirect_valid and redirect_pc are registered. They rise the cycle after the mispredicting branch retires and last exactly 1 cycle.
- Mispredict retire to first possible next commit is 2 + RECOVER_CYCLES cycles.
- Reset values: state = RUN, flush = 0, redirect_valid = 0, redirect_pc = 0, recovering = 0, instret = 0, recover counter = 0.
- The combinational outputs are 0 while rob_count == 0.
- rst_n asserted mid-FLUSH or mid-RECOVER aborts immediately to reset values. No partial flush pulse is extended.
- rob_count == 1 with head_finish[1] == 1 (a stale bit): slot 1 must not commit.
- Head wrap-around (head = NUM_ROB_ENTRY-1) is transparent; the block uses no indices.

## Structure
- Add to typedef_pkg: the commit_state_t enum {RUN, FLUSH, RECOVER} and ROB_ENTRY_t, which is reused as is.
- Add to instruction_pkg: opcode constants for STORE, BRANCH, JAL and JALR, plus is_store/is_ctrl helper functions.
- Sub-module commit_slot_decode: combinational. Maps ROB_ENTRY_t to is_store, is_ctrl, writes_rd. It is instantiated twice.

## Test plan
- rob_count = 2, both finished ALU ops (rd 3→p10 old p4, rd 5→p11 old p7) -> commit_cnt = 2, free p4 and p7, ARAT 3→10 and 5→11, instret += 2.
- rob_count = 2, head_finish = 2'b10 -> commit_cnt = 0 and all strobes 0. Then the next cycle with 2'b11 gives commit_cnt = 2.
- Two finished stores (store_id 1 then 2) -> cycle N commits id 1 with commit_cnt = 1; cycle N+1 commits id 2.
- Mispredicted branch at head (actual_target 0x0000_0200), finished ALU op behind it -> commit_cnt = 1 and bp_update_valid = 1. Next cycle: flush = 1, redirect_pc = 0x200. Then 2 cycles with commit_cnt = 0, then RUN.
- Slot 0 rd_arch = 0 -> free_valid[0] = 0 and arat_we[0] = 0 while retire_valid[0] = 1.
- rst_n pulled low during RECOVER -> flush = 0, recovering = 0, instret = 0 immediately. After release, a finished head commits on the first edge.

Source files
------------

// File: rtl/instruction_pkg.sv
// Opcode constants and classification helpers shared by the retirement path.
package instruction_pkg;

    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    function automatic logic is_store(input logic [6:0] opcode);
        return opcode == OPCODE_STORE;
    endfunction

    function automatic logic is_ctrl(input logic [6:0] opcode);
        return (opcode == OPCODE_BRANCH) || (opcode == OPCODE_JAL) || (opcode == OPCODE_JALR);
    endfunction

endpackage

// File: rtl/typedef_pkg.sv
// Shared types for the back end: commit FSM states and the reorder buffer entry layout.
package typedef_pkg;

    localparam int PHY_W      = 6;
    localparam int ARCH_W     = 5;
    localparam int XLEN_W     = 32;
    localparam int STORE_ID_W = 4;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        RECOVER
    } commit_state_t;

    typedef struct packed {
        logic [6:0]            opcode;
        logic [ARCH_W-1:0]     rd_arch;
        logic [PHY_W-1:0]      rd_phy_new;
        logic [PHY_W-1:0]      rd_phy_old;
        logic [STORE_ID_W-1:0] store_id;
        logic                  mispredict;
        logic                  actual_taken;
        logic [XLEN_W-1:0]     update_pc;
        logic [XLEN_W-1:0]     actual_target;
    } ROB_ENTRY_t;

endpackage

// File: rtl/commit_slot_decode.sv
// Classifies one ROB head entry for the commit stage: store, control transfer, register writer.
module commit_slot_decode
    import typedef_pkg::*;
    import instruction_pkg::*;
(
    input  ROB_ENTRY_t entry_i,
    output logic       is_store_o,
    output logic       is_ctrl_o,
    output logic       writes_rd_o
);

    logic unusedFields;

    assign is_store_o  = is_store(entry_i.opcode);
    assign is_ctrl_o   = is_ctrl(entry_i.opcode);
    assign writes_rd_o = (entry_i.rd_arch != '0);

    // The payload fields are consumed by the commit stage itself, not by the classifier.
    assign unusedFields = ^{entry_i.rd_phy_new, entry_i.rd_phy_old, entry_i.store_id,
                            entry_i.mispredict, entry_i.actual_taken, entry_i.update_pc,
                            entry_i.actual_target};

endmodule

// File: rtl/commit_controller.sv
// Two-wide in-order retirement sequencer with a flush/redirect/recover sequence on head mispredicts.
module commit_controller
    import typedef_pkg::*;
#(
    parameter int NUM_ROB_ENTRY  = 16,
    parameter int ROB_WIDTH      = $clog2(NUM_ROB_ENTRY),
    parameter int PHY_WIDTH      = 6,
    parameter int ARCH_WIDTH     = 5,
    parameter int XLEN           = 32,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ROB_WIDTH:0]    rob_count,
    input  logic [1:0]            head_finish,
    input  ROB_ENTRY_t            head_entry_0,
    input  ROB_ENTRY_t            head_entry_1,
    output logic [1:0]            commit_cnt,
    output logic [1:0]            retire_valid,
    output logic [1:0]            free_valid,
    output logic [PHY_WIDTH-1:0]  free_phy_0,
    output logic [PHY_WIDTH-1:0]  free_phy_1,
    output logic [1:0]            arat_we,
    output logic [ARCH_WIDTH-1:0] arat_arch_0,
    output logic [ARCH_WIDTH-1:0] arat_arch_1,
    output logic [PHY_WIDTH-1:0]  arat_phy_0,
    output logic [PHY_WIDTH-1:0]  arat_phy_1,
    output logic                  store_commit_valid,
    output logic [STORE_ID_W-1:0] store_commit_id,
    output logic                  bp_update_valid,
    output logic [XLEN-1:0]       bp_update_pc,
    output logic [XLEN-1:0]       bp_update_target,
    output logic                  bp_update_taken,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    output logic                  recovering,
    output logic [63:0]           instret
);

    localparam int CNT_W = $clog2(RECOVER_CYCLES + 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES - 1);

    commit_state_t    state_q, state_d;
    logic [CNT_W-1:0] recoverCnt_q, recoverCnt_d;
    logic [XLEN-1:0]  redirectPc_q, redirectPc_d;
    logic             flush_q, flush_d;
    logic [63:0]      instret_q, instret_d;

    logic isStore0, isCtrl0, writesRd0;
    logic isStore1, isCtrl1, writesRd1;
    logic commit0, commit1;

    commit_slot_decode u_decode0 (
        .entry_i     (head_entry_0),
        .is_store_o  (isStore0),
        .is_ctrl_o   (isCtrl0),
        .writes_rd_o (writesRd0)
    );

    commit_slot_decode u_decode1 (
        .entry_i     (head_entry_1),
        .is_store_o  (isStore1),
        .is_ctrl_o   (isCtrl1),
        .writes_rd_o (writesRd1)
    );

    // Slot 1 yields to slot 0 whenever they would contend for the single store or predictor port.
    assign commit0 = (state_q == RUN) && (rob_count != '0) && head_finish[0];
    assign commit1 = commit0 && (rob_count >= (ROB_WIDTH+1)'(2)) && head_finish[1]
                     && !head_entry_0.mispredict
                     && !(isStore0 && isStore1)
                     && !(isCtrl0 && isCtrl1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            recoverCnt_q <= '0;
            redirectPc_q <= '0;
            flush_q      <= 1'b0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            recoverCnt_q <= recoverCnt_d;
            redirectPc_q <= redirectPc_d;
            flush_q      <= flush_d;
            instret_q    <= instret_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        recoverCnt_d = recoverCnt_q;
        redirectPc_d = redirectPc_q;
        unique case (state_q)
            RUN: begin
                if (commit0 && head_entry_0.mispredict) begin
                    state_d      = FLUSH;
                    redirectPc_d = head_entry_0.actual_target;
                end
            end
            FLUSH: begin
                state_d      = RECOVER;
                recoverCnt_d = RECOVER_LOAD;
            end
            RECOVER: begin
                if (recoverCnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    recoverCnt_d = recoverCnt_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        flush_d   = (state_d == FLUSH);
        instret_d = instret_q + 64'(commit_cnt);
    end

    always_comb begin
        commit_cnt         = 2'(commit0) + 2'(commit1);
        retire_valid       = {commit1, commit0};
        free_valid         = {commit1 && writesRd1, commit0 && writesRd0};
        arat_we            = free_valid;
        free_phy_0         = '0;
        free_phy_1         = '0;
        arat_arch_0        = '0;
        arat_arch_1        = '0;
        arat_phy_0         = '0;
        arat_phy_1         = '0;
        store_commit_valid = 1'b0;
        store_commit_id    = '0;
        bp_update_valid    = 1'b0;
        bp_update_pc       = '0;
        bp_update_target   = '0;
        bp_update_taken    = 1'b0;
        if (free_valid[0]) begin
            free_phy_0  = head_entry_0.rd_phy_old;
            arat_arch_0 = head_entry_0.rd_arch;
            arat_phy_0  = head_entry_0.rd_phy_new;
        end
        if (free_valid[1]) begin
            free_phy_1  = head_entry_1.rd_phy_old;
            arat_arch_1 = head_entry_1.rd_arch;
            arat_phy_1  = head_entry_1.rd_phy_new;
        end
        if (commit0 && isStore0) begin
            store_commit_valid = 1'b1;
            store_commit_id    = head_entry_0.store_id;
        end else if (commit1 && isStore1) begin
            store_commit_valid = 1'b1;
            store_commit_id    = head_entry_1.store_id;
        end
        if (commit0 && isCtrl0) begin
            bp_update_valid  = 1'b1;
            bp_update_pc     = head_entry_0.update_pc;
            bp_update_target = head_entry_0.actual_target;
            bp_update_taken  = head_entry_0.actual_taken;
        end else if (commit1 && isCtrl1) begin
            bp_update_valid  = 1'b1;
            bp_update_pc     = head_entry_1.update_pc;
            bp_update_target = head_entry_1.actual_target;
            bp_update_taken  = head_entry_1.actual_taken;
        end
        flush          = flush_q;
        redirect_valid = flush_q;
        redirect_pc    = redirectPc_q;
        recovering     = (state_q != RUN);
        instret        = instret_q;
    end

endmodule

// File: tb/tb_commit_controller.sv
// Directed and randomized bench for commit_controller against a cycle-budget retirement model.
module tb_commit_controller;
    import typedef_pkg::*;

    localparam int RC = 2;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rob_count;
    logic [1:0]  head_finish;
    ROB_ENTRY_t  head_entry_0, head_entry_1;
    logic [1:0]  commit_cnt, retire_valid, free_valid, arat_we;
    logic [5:0]  free_phy_0, free_phy_1, arat_phy_0, arat_phy_1;
    logic [4:0]  arat_arch_0, arat_arch_1;
    logic        store_commit_valid;
    logic [3:0]  store_commit_id;
    logic        bp_update_valid, bp_update_taken;
    logic [31:0] bp_update_pc, bp_update_target;
    logic        flush, redirect_valid, recovering;
    logic [31:0] redirect_pc;
    logic [63:0] instret;

    int vectors = 0;
    int miscompares = 0;

    int          blockLeft = 0;
    logic [31:0] mRedirectPc = '0;
    logic [63:0] mInstret = '0;

    commit_controller #(.RECOVER_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n), .rob_count(rob_count), .head_finish(head_finish),
        .head_entry_0(head_entry_0), .head_entry_1(head_entry_1),
        .commit_cnt(commit_cnt), .retire_valid(retire_valid), .free_valid(free_valid),
        .free_phy_0(free_phy_0), .free_phy_1(free_phy_1), .arat_we(arat_we),
        .arat_arch_0(arat_arch_0), .arat_arch_1(arat_arch_1),
        .arat_phy_0(arat_phy_0), .arat_phy_1(arat_phy_1),
        .store_commit_valid(store_commit_valid), .store_commit_id(store_commit_id),
        .bp_update_valid(bp_update_valid), .bp_update_pc(bp_update_pc),
        .bp_update_target(bp_update_target), .bp_update_taken(bp_update_taken),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .recovering(recovering), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic ROB_ENTRY_t mkEntry(logic [6:0] op, logic [4:0] rd, logic [5:0] pNew,
                                           logic [5:0] pOld, logic [3:0] sid, logic mis,
                                           logic taken, logic [31:0] pc, logic [31:0] tgt);
        ROB_ENTRY_t e;
        e.opcode = op; e.rd_arch = rd; e.rd_phy_new = pNew; e.rd_phy_old = pOld;
        e.store_id = sid; e.mispredict = mis; e.actual_taken = taken;
        e.update_pc = pc; e.actual_target = tgt;
        return e;
    endfunction

    function automatic ROB_ENTRY_t randEntry();
        logic [6:0] ops [6] = '{OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
        logic [6:0] op = ops[$urandom_range(0, 5)];
        logic [4:0] rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        logic ctrl = (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
        logic mis = ctrl && ($urandom_range(0, 3) == 0);
        return mkEntry(op, rd, 6'($urandom), 6'($urandom), 4'($urandom), mis,
                       1'($urandom), $urandom, $urandom);
    endfunction

    task automatic checkField(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(int cnt, logic [1:0] fin, ROB_ENTRY_t a, ROB_ENTRY_t b);
        rob_count    = 5'(cnt);
        head_finish  = fin;
        head_entry_0 = a;
        head_entry_1 = b;
    endtask

    // Compares every output against the retirement rules, then advances the model across the next edge.
    task automatic checkOutput();
        ROB_ENTRY_t e0 = head_entry_0;
        ROB_ENTRY_t e1 = head_entry_1;
        logic st0 = (e0.opcode == OP_STORE);
        logic st1 = (e1.opcode == OP_STORE);
        logic br0 = (e0.opcode == OP_BRANCH) || (e0.opcode == OP_JAL) || (e0.opcode == OP_JALR);
        logic br1 = (e1.opcode == OP_BRANCH) || (e1.opcode == OP_JAL) || (e1.opcode == OP_JALR);
        logic c0 = (blockLeft == 0) && (int'(rob_count) >= 1) && head_finish[0];
        logic c1 = c0 && (int'(rob_count) >= 2) && head_finish[1] && !e0.mispredict
                   && !(st0 && st1) && !(br0 && br1);
        logic w0 = c0 && (e0.rd_arch != 0);
        logic w1 = c1 && (e1.rd_arch != 0);
        int expCnt = int'(c0) + int'(c1);
        checkField("commit_cnt", 64'(commit_cnt), 64'(expCnt));
        checkField("retire_valid", 64'(retire_valid), 64'({c1, c0}));
        checkField("free_valid", 64'(free_valid), 64'({w1, w0}));
        checkField("arat_we", 64'(arat_we), 64'({w1, w0}));
        if (w0) begin
            checkField("free_phy_0", 64'(free_phy_0), 64'(e0.rd_phy_old));
            checkField("arat_0", 64'({arat_arch_0, arat_phy_0}), 64'({e0.rd_arch, e0.rd_phy_new}));
        end
        if (w1) begin
            checkField("free_phy_1", 64'(free_phy_1), 64'(e1.rd_phy_old));
            checkField("arat_1", 64'({arat_arch_1, arat_phy_1}), 64'({e1.rd_arch, e1.rd_phy_new}));
        end
        checkField("store_valid", 64'(store_commit_valid), 64'((c0 && st0) || (c1 && st1)));
        if ((c0 && st0) || (c1 && st1))
            checkField("store_id", 64'(store_commit_id), 64'((c0 && st0) ? e0.store_id : e1.store_id));
        checkField("bp_valid", 64'(bp_update_valid), 64'((c0 && br0) || (c1 && br1)));
        if (c0 && br0)
            checkField("bp_0", {bp_update_pc, bp_update_target}, {e0.update_pc, e0.actual_target});
        else if (c1 && br1)
            checkField("bp_1", {bp_update_pc, bp_update_target}, {e1.update_pc, e1.actual_target});
        if ((c0 && br0) || (c1 && br1))
            checkField("bp_taken", 64'(bp_update_taken),
                       64'((c0 && br0) ? e0.actual_taken : e1.actual_taken));
        if (expCnt == 0)
            checkField("quiet", 64'(|{retire_valid, free_valid, arat_we, free_phy_0, free_phy_1,
                                     arat_arch_0, arat_arch_1, arat_phy_0, arat_phy_1,
                                     store_commit_valid, store_commit_id, bp_update_valid,
                                     bp_update_pc, bp_update_target, bp_update_taken}), 64'(0));
        checkField("flush", 64'(flush), 64'(blockLeft == RC + 1));
        checkField("redirect_valid", 64'(redirect_valid), 64'(blockLeft == RC + 1));
        checkField("recovering", 64'(recovering), 64'(blockLeft > 0));
        checkField("redirect_pc", 64'(redirect_pc), 64'(mRedirectPc));
        checkField("instret", instret, mInstret);
        mInstret = mInstret + 64'(expCnt);
        if (c0 && e0.mispredict) begin
            blockLeft   = RC + 1;
            mRedirectPc = e0.actual_target;
        end else if (blockLeft > 0) begin
            blockLeft--;
        end
    endtask

    task automatic stepCycle(int cnt, logic [1:0] fin, ROB_ENTRY_t a, ROB_ENTRY_t b);
        applyStimulus(cnt, fin, a, b);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ROB_ENTRY_t aluA, aluB, st1, st2, br, zeroRd;
        aluA   = mkEntry(OP_ALU, 5'd3, 6'd10, 6'd4, 4'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        aluB   = mkEntry(OP_ALU, 5'd5, 6'd11, 6'd7, 4'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        st1    = mkEntry(OP_STORE, 5'd0, 6'd0, 6'd0, 4'd1, 1'b0, 1'b0, 32'h0, 32'h0);
        st2    = mkEntry(OP_STORE, 5'd0, 6'd0, 6'd0, 4'd2, 1'b0, 1'b0, 32'h0, 32'h0);
        br     = mkEntry(OP_BRANCH, 5'd0, 6'd0, 6'd0, 4'd0, 1'b1, 1'b1, 32'h100, 32'h200);
        zeroRd = mkEntry(OP_ALU, 5'd0, 6'd20, 6'd21, 4'd0, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("[TB] reset");
        rst_n = 1'b0;
        applyStimulus(0, 2'b00, aluA, aluB);
        #12;
        checkOutput();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed sequence");
        stepCycle(2, 2'b11, aluA, aluB);
        stepCycle(2, 2'b10, aluA, aluB);
        stepCycle(2, 2'b11, aluA, aluB);
        stepCycle(1, 2'b11, aluA, aluB);
        stepCycle(2, 2'b11, st1, st2);
        stepCycle(1, 2'b01, st2, aluA);
        stepCycle(2, 2'b11, zeroRd, aluA);
        stepCycle(2, 2'b11, br, aluA);
        for (int i = 0; i < RC + 2; i++) stepCycle(2, 2'b11, aluA, aluB);

        $display("[TB] reset during recovery");
        stepCycle(2, 2'b11, br, aluA);
        stepCycle(2, 2'b11, aluA, aluB);
        rst_n = 1'b0;
        #1;
        checkField("rst_flush", 64'(flush), 64'(0));
        checkField("rst_recovering", 64'(recovering), 64'(0));
        checkField("rst_instret", instret, 64'(0));
        checkField("rst_redirect_pc", 64'(redirect_pc), 64'(0));
        blockLeft   = 0;
        mInstret    = '0;
        mRedirectPc = '0;
        applyStimulus(1, 2'b01, aluA, aluB);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput();
        @(posedge clk);
        #1;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++)
            stepCycle($urandom_range(0, 16), 2'($urandom), randEntry(), randEntry());
        stepCycle(0, 2'b00, aluA, aluB);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
